// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared optype indices, forward-select and halt-state encodings
//               for the RV32I pipeline sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Bit positions inside the one-hot ID optype bus
    localparam int R       = 0;
    localparam int I_LOADS = 1;
    localparam int I_ARITH = 2;
    localparam int I_ECALL = 3;
    localparam int I_JALR  = 4;
    localparam int S       = 5;
    localparam int B       = 6;
    localparam int U_AUIPC = 7;
    localparam int U_LUI   = 8;
    localparam int J_JAL   = 9;

    // EX operand mux select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // ecall drain/halt sequencing
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        HALT  = 2'b10
    } halt_state_t;

    // A producer matches a consumer only for a real (non-x0) register
    function automatic logic rs_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : ID-stage fields in, pipeline control out, for hazard_ctrl.
//               master = core side driving ID fields, slave = hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int OPTYPE_W = 10
);
    logic                id_valid;
    logic [OPTYPE_W-1:0] id_optype;
    logic [4:0]          id_rs1;
    logic [4:0]          id_rs2;
    logic [4:0]          id_rd;
    logic                ex_br_taken;
    logic                mem_ready;
    logic                stall_if;
    logic                stall_id;
    logic                flush_id;
    logic                bubble_ex;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                halted;

    modport master (
        output id_valid, id_optype, id_rs1, id_rs2, id_rd, ex_br_taken, mem_ready,
        input  stall_if, stall_id, flush_id, bubble_ex, fwd_a, fwd_b, halted
    );

    modport slave (
        input  id_valid, id_optype, id_rs1, id_rs2, id_rd, ex_br_taken, mem_ready,
        output stall_if, stall_id, flush_id, bubble_ex, fwd_a, fwd_b, halted
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Forward-select for one EX operand. MEM beats WB because MEM
//               holds the younger write to the same register.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import pipe_pkg::*;
(
    input  wire logic [4:0] i_rs,
    input  wire logic       i_mem_v,
    input  wire logic [4:0] i_mem_rd,
    input  wire logic       i_wb_v,
    input  wire logic [4:0] i_wb_rd,
    output fwd_sel_t        o_sel
);

    // Pick the youngest in-flight producer of this operand, else the regfile
    always_comb begin
        o_sel = FWD_RF;
        if (i_mem_v && rs_match(i_mem_rd, i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_wb_v && rs_match(i_wb_rd, i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Five-stage RV32I pipeline sequencing controller: stall, flush,
//               bubble, EX forwarding selects and the ecall drain/halt FSM.
//               Keeps its own EX/MEM/WB destination shadow.
//               Macro FWD_EN: defined -> EX operand forwarding from MEM/WB;
//               undefined -> no forwarding, ID stalls on any RAW against a
//               valid EX or MEM producer.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int OPTYPE_W     = 10
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_ctrl_if.slave bus
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DRAIN_CYCLES - 1);

`ifdef FWD_EN
    localparam bit c_fwd_en = 1'b1;
`else
    localparam bit c_fwd_en = 1'b0;
`endif

    // Shadow of the in-flight destinations
    logic        r_ex_v;
    logic [4:0]  r_ex_rd;
    logic [4:0]  r_ex_rs1;
    logic [4:0]  r_ex_rs2;
    logic        r_ex_is_load;
    logic        r_mem_v;
    logic [4:0]  r_mem_rd;
    logic        r_wb_v;
    logic [4:0]  r_wb_rd;

    // Halt FSM
    halt_state_t      r_state;
    halt_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [OPTYPE_W-1:0] w_optype;
    logic     w_hit_ex;
    logic     w_hit_mem;
    logic     w_load_use;
    logic     w_data_hazard;
    logic     w_stall_if;
    logic     w_stall_id;
    logic     w_flush;
    logic     w_bubble;
    logic     w_halted;
    logic     w_accept;
    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;

    assign w_optype = bus.id_optype;

    // ID sources against the EX and MEM producers (x0 never matches)
    assign w_hit_ex  = bus.id_valid && r_ex_v &&
                       (rs_match(r_ex_rd, bus.id_rs1) || rs_match(r_ex_rd, bus.id_rs2));
    assign w_hit_mem = bus.id_valid && r_mem_v &&
                       (rs_match(r_mem_rd, bus.id_rs1) || rs_match(r_mem_rd, bus.id_rs2));
    assign w_load_use = w_hit_ex && r_ex_is_load;

    // Without forwarding every RAW on an EX/MEM producer waits for WB
    assign w_data_hazard = c_fwd_en ? w_load_use : (w_hit_ex || w_hit_mem);

    // Control outputs, acceptance and halt FSM next state
    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_halted    = 1'b0;
        w_accept    = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (r_state == HALT) begin
            w_halted   = 1'b1;
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
        end else begin
            // Memory wait freezes everything; a pending redirect waits for it
            if (!bus.mem_ready) begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
            end else if (bus.ex_br_taken) begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
            end else if (w_data_hazard) begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_bubble   = 1'b1;
            end
            // While draining, fetch is held and nothing new enters EX
            if (r_state == DRAIN) begin
                w_stall_if = 1'b1;
                w_bubble   = 1'b1;
            end
        end

        w_accept = bus.id_valid && !w_stall_id && !w_flush;

        case (r_state)
            RUN: begin
                if (w_accept && !w_bubble && w_optype[I_ECALL]) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            DRAIN: begin
                if (bus.mem_ready) begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = HALT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Halt FSM state and drain counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow pipeline advances only when memory lets the pipe move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v       <= 1'b0;
            r_ex_rd      <= 5'd0;
            r_ex_rs1     <= 5'd0;
            r_ex_rs2     <= 5'd0;
            r_ex_is_load <= 1'b0;
            r_mem_v      <= 1'b0;
            r_mem_rd     <= 5'd0;
            r_wb_v       <= 1'b0;
            r_wb_rd      <= 5'd0;
        end else if (bus.mem_ready) begin
            r_ex_v       <= w_accept && !w_bubble;
            r_ex_rd      <= bus.id_rd;
            r_ex_rs1     <= bus.id_rs1;
            r_ex_rs2     <= bus.id_rs2;
            r_ex_is_load <= w_optype[I_LOADS];
            r_mem_v      <= r_ex_v;
            r_mem_rd     <= r_ex_rd;
            r_wb_v       <= r_mem_v;
            r_wb_rd      <= r_mem_rd;
        end
    end

    fwd_unit u_fwd_a (
        .i_rs     (r_ex_rs1),
        .i_mem_v  (r_mem_v),
        .i_mem_rd (r_mem_rd),
        .i_wb_v   (r_wb_v),
        .i_wb_rd  (r_wb_rd),
        .o_sel    (w_sel_a)
    );

    fwd_unit u_fwd_b (
        .i_rs     (r_ex_rs2),
        .i_mem_v  (r_mem_v),
        .i_mem_rd (r_mem_rd),
        .i_wb_v   (r_wb_v),
        .i_wb_rd  (r_wb_rd),
        .o_sel    (w_sel_b)
    );

    assign bus.stall_if  = w_stall_if;
    assign bus.stall_id  = w_stall_id;
    assign bus.flush_id  = w_flush;
    assign bus.bubble_ex = w_bubble;
    assign bus.halted    = w_halted;
    assign bus.fwd_a     = c_fwd_en ? w_sel_a : FWD_RF;
    assign bus.fwd_b     = c_fwd_en ? w_sel_b : FWD_RF;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int c_ow = 10;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if #(.OPTYPE_W(c_ow)) bus ();

    hazard_ctrl #(
        .DRAIN_CYCLES (3),
        .OPTYPE_W     (c_ow)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FWD_EN
    localparam logic [3:0] c_fwd_mem = 4'd1;
`else
    localparam logic [3:0] c_fwd_mem = 4'd0;
`endif

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an ID instruction and let the combinational outputs settle
    task automatic drive(input logic v, input int opidx,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_valid  = v;
        bus.id_optype = v ? (c_ow'(1) << opidx) : '0;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        repeat (n) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.ex_br_taken = 1'b0;
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall_if", bus.stall_if, 0);
        check_eq("rst_stall_id", bus.stall_id, 0);
        check_eq("rst_flush",    bus.flush_id, 0);
        check_eq("rst_bubble",   bus.bubble_ex, 0);
        check_eq("rst_fwd_a",    bus.fwd_a, 0);
        check_eq("rst_fwd_b",    bus.fwd_b, 0);
        check_eq("rst_halted",   bus.halted, 0);
        rst_n = 1'b1;
        step();

        // lw x5,0(x1) then add x6,x5,x2
        drive(1'b1, I_LOADS, 5'd1, 5'd0, 5'd5);
        check_eq("lw_no_stall", bus.stall_id, 0);
        step();
        drive(1'b1, R, 5'd5, 5'd2, 5'd6);
        check_eq("lu_stall_if", bus.stall_if, 1);
        check_eq("lu_stall_id", bus.stall_id, 1);
        check_eq("lu_bubble",   bus.bubble_ex, 1);
        step();
`ifdef FWD_EN
        check_eq("lu_release", bus.stall_id, 0);
        step();
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        check_eq("lu_fwd_a_wb", bus.fwd_a, 2);
        check_eq("lu_fwd_b_rf", bus.fwd_b, 0);
`else
        check_eq("raw_mem_stall",  bus.stall_id, 1);
        check_eq("raw_mem_bubble", bus.bubble_ex, 1);
        step();
        check_eq("raw_wb_free", bus.stall_id, 0);
        step();
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        check_eq("nofwd_a", bus.fwd_a, 0);
`endif
        idle(3);

        // add x3,x1,x2 then sub x4,x3,x3
        drive(1'b1, R, 5'd1, 5'd2, 5'd3);
        check_eq("add_no_stall", bus.stall_id, 0);
        step();
        drive(1'b1, R, 5'd3, 5'd3, 5'd4);
`ifdef FWD_EN
        check_eq("b2b_no_stall", bus.stall_id, 0);
        step();
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        check_eq("b2b_fwd_a_mem", bus.fwd_a, 1);
        check_eq("b2b_fwd_b_mem", bus.fwd_b, 1);
`else
        check_eq("b2b_ex_stall",  bus.stall_id, 1);
        check_eq("b2b_ex_bubble", bus.bubble_ex, 1);
        step();
        check_eq("b2b_mem_stall", bus.stall_id, 1);
        step();
        check_eq("b2b_wb_free", bus.stall_id, 0);
        step();
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        check_eq("b2b_fwd_b_off", bus.fwd_b, 0);
`endif
        idle(3);

        // Load-use together with a redirect: flush wins
        drive(1'b1, I_LOADS, 5'd1, 5'd0, 5'd5);
        step();
        drive(1'b1, R, 5'd5, 5'd2, 5'd6);
        bus.ex_br_taken = 1'b1;
        #1;
        check_eq("br_flush",    bus.flush_id, 1);
        check_eq("br_bubble",   bus.bubble_ex, 1);
        check_eq("br_stall_id", bus.stall_id, 0);
        check_eq("br_stall_if", bus.stall_if, 0);
        step();
        bus.ex_br_taken = 1'b0;
        idle(3);

        // x0 never hazards or forwards
        drive(1'b1, R, 5'd1, 5'd2, 5'd0);
        step();
        drive(1'b1, R, 5'd0, 5'd0, 5'd7);
        check_eq("x0_no_stall", bus.stall_id, 0);
        step();
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
        check_eq("x0_fwd_a", bus.fwd_a, 0);
        check_eq("x0_fwd_b", bus.fwd_b, 0);
        idle(3);

        // Memory wait with a producer in MEM, redirect arriving mid-wait
        drive(1'b1, R, 5'd1, 5'd2, 5'd3);
        step();
`ifdef FWD_EN
        drive(1'b1, R, 5'd3, 5'd0, 5'd4);
`else
        drive(1'b0, R, 5'd0, 5'd0, 5'd0);
`endif
        step();
        drive(1'b1, I_ARITH, 5'd1, 5'd0, 5'd9);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ex_br_taken = (i >= 2);
            #1;
            check_eq("mw_stall_if", bus.stall_if, 1);
            check_eq("mw_stall_id", bus.stall_id, 1);
            check_eq("mw_bubble",   bus.bubble_ex, 0);
            check_eq("mw_flush",    bus.flush_id, 0);
            check_eq("mw_fwd_a",    bus.fwd_a, c_fwd_mem);
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        check_eq("mw_br_flush",  bus.flush_id, 1);
        check_eq("mw_br_bubble", bus.bubble_ex, 1);
        check_eq("mw_release",   bus.stall_id, 0);
        check_eq("mw_fwd_hold",  bus.fwd_a, c_fwd_mem);
        step();
        bus.ex_br_taken = 1'b0;
        idle(3);

        // ecall drain and halt
        drive(1'b1, I_ECALL, 5'd0, 5'd0, 5'd0);
        check_eq("ec_n_stall_if", bus.stall_if, 0);
        step();
        drive(1'b1, I_ARITH, 5'd0, 5'd0, 5'd10);
        check_eq("ec_n1_stall_if", bus.stall_if, 1);
        check_eq("ec_n1_bubble",   bus.bubble_ex, 1);
        check_eq("ec_n1_halted",   bus.halted, 0);
        step();
        check_eq("ec_n2_stall_if", bus.stall_if, 1);
        check_eq("ec_n2_halted",   bus.halted, 0);
        step();
        check_eq("ec_n3_halted",   bus.halted, 1);
        check_eq("ec_n3_stall_if", bus.stall_if, 1);
        check_eq("ec_n3_stall_id", bus.stall_id, 1);
        step();
        check_eq("ec_sticky", bus.halted, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ec_async_rst_halted", bus.halted, 0);
        check_eq("ec_async_rst_stall",  bus.stall_id, 0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_halted", bus.halted, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage RV32I core. It consumes the decoded ID-stage fields (optype one-hot, rs1/rs2/rd) and keeps its own shadow of EX/MEM/WB destination state. It drives stall, flush, bubble and forwarding-select controls, and runs the ecall drain/halt sequence. It sits beside the decoder in ID; its outputs go to the IF/ID and ID/EX pipeline registers and to the EX operand muxes.

Parameters:
DRAIN_CYCLES, 3, cycles from ecall entering EX until it retires in WB; sets the halt point.
OPTYPE_W, 10, width of the one-hot optype bus.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_optype  in  OPTYPE_W  one-hot optype of the ID instruction (package indices)
id_rs1  in  5  ID source 1; 0 when unused
id_rs2  in  5  ID source 2; 0 when unused
id_rd  in  5  ID destination; 0 when none
ex_br_taken  in  1  EX resolved a redirect (taken branch, jal, jalr)
mem_ready  in  1  data memory accepted or completed the MEM access; low freezes the pipe
stall_if  out  1  hold PC and IF/ID
stall_id  out  1  hold ID/EX inputs; ID instruction not accepted
flush_id  out  1  squash IF/ID contents
bubble_ex  out  1  load a NOP into ID/EX
fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM result, 10 WB result
fwd_b  out  2  EX operand B select, same encoding
halted  out  1  ecall retired; core stopped

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset clears all shadow valids, sets state RUN, halted=0. With shadow valids at 0, every stall/flush/bubble output is 0 and fwd_a/fwd_b are 00.
- Shadow stages: EX{v,rd,rs1,rs2,is_load,is_ecall}, then MEM{v,rd}, then WB{v,rd}.
- The shadow advances every cycle that mem_ready=1. With mem_ready=0 it holds.
- The ID instruction enters EX shadow only when accepted: id_valid & ~stall_id & ~flush_id. On a bubble, EX.v=0.
- x0 rule: rd or rs equal to 0 never creates a hazard or a forward.
- Load-use: EX.v & EX.is_load & EX.rd!=0 & (EX.rd==id_rs1 | EX.rd==id_rs2) & id_valid gives stall_if=stall_id=1 and bubble_ex=1 for one cycle.
- Redirect: ex_br_taken=1 gives flush_id=1 and bubble_ex=1 in the same cycle. The two younger instructions are squashed.
- Priority: ex_br_taken over load-use. When both hold, flush wins and no stall is raised.
- Memory wait: mem_ready=0 gives stall_if=stall_id=1 and bubble_ex=0 (EX holds), and flush_id=0. A pending ex_br_taken is honoured in the first cycle mem_ready=1.
- Forwarding, combinational on shadow state: fwd_a=01 if MEM.v & MEM.rd!=0 & MEM.rd==EX.rs1. Otherwise 10 if the same test passes against WB. Otherwise 00. fwd_b is the same against EX.rs2. MEM has priority over WB.
- The regfile is write-before-read, so WB to ID needs no control.
- Halt FSM has three states:
  - RUN: when an ecall is accepted into EX, go to DRAIN. The counter loads DRAIN_CYCLES-1 and stall_if=1 from the next cycle.
  - DRAIN: stall_if=1 and bubble_ex=1 every cycle. The counter decrements only when mem_ready=1. At 0, go to HALT.
  - HALT: halted=1, stall_if=stall_id=1. Sticky until rst_n.
- An ecall flushed by ex_br_taken never enters DRAIN.
- Reset asserted mid-DRAIN or mid-stall returns immediately to the reset state.
- Control outputs are combinational from current inputs plus registered shadow/FSM state. There is no extra latency.

Optional Feature:
FWD_EN:
- Defined: forwarding as above.
- Undefined: fwd_a=fwd_b=00 always. Any RAW match of id_rs1/id_rs2 against a valid EX.rd or MEM.rd (non-zero) stalls ID and bubbles EX until the producer reaches WB. Load-use becomes a subset of this rule.

Decomposition:
- Package pipe_pkg holds:
  - optype index localparams (R=0, I_LOADS=1, I_ARITH=2, I_ECALL=3, I_JALR=4, S=5, B=6, U_AUIPC=7, U_LUI=8, J_JAL=9)
  - the fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB)
  - the halt_state_t enum (RUN, DRAIN, HALT)
- One natural sub-module: fwd_unit, the combinational forward-select logic for one operand, instantiated twice.

Test Plan:
- `lw x5,0(x1)` in EX, `add x6,x5,x2` in ID -> stall_if=stall_id=bubble_ex=1 for 1 cycle; next cycle fwd_a=10 (WB) for the add.
- `add x3,x1,x2` then `sub x4,x3,x3` back-to-back -> no stall; sub in EX sees fwd_a=fwd_b=01.
- Load-use condition with ex_br_taken=1 in the same cycle -> flush_id=1, bubble_ex=1, stall_id=0.
- `add x0,x1,x2` followed by `add x7,x0,x0` -> fwd 00, no stall.
- mem_ready low 4 cycles with a producer in MEM -> stall_if/stall_id high 4 cycles; shadow frozen; fwd_a unchanged throughout.
- ecall accepted at cycle N -> stall_if from N+1; halted=1 at N+3 with DRAIN_CYCLES=3 and mem_ready=1; rst_n pulse clears halted=0 asynchronously.
